// File: rtl/div_share_arb.sv
// -----------------------------------------------------------------------------
// div_share_arb
//
// Shared divide-by-2^SHIFT engine serving four requesters. One operand is
// granted at a time, loaded into a single shift register, shifted right by
// one bit per cycle for SHIFT cycles, and returned on a valid/ready response
// channel tagged with the owning requester index.
//
// Configuration macro:
//   DIV_SHARE_RR_EN  defined   -> round-robin arbitration (rotating pointer)
//                    undefined -> fixed priority, lowest asserted index wins
//
// Parameters:
//   WIDTH      operand/result width in bits
//   SHIFT      divisor exponent, quotient = operand >> SHIFT (1..WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_data   operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot accept strobe to the granted requester (IDLE only)
//   rsp_valid  quotient available
//   rsp_ready  consumer accepts quotient
//   rsp_data   quotient
//   rsp_id     index of the requester owning rsp_data
// -----------------------------------------------------------------------------
module div_share_arb #(
    parameter int WIDTH = 4,
    parameter int SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [1:0]         rsp_id
);

    // State table
    //   ST_IDLE  | waiting for a request; req_ready strobes the winner
    //   ST_SHIFT | shifting the granted operand one bit per cycle
    //   ST_DONE  | quotient presented, held until rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must hold values up to SHIFT, and SHIFT may equal WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SHIFT - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [1:0]       grant;
    logic             any_req;
    logic [WIDTH-1:0] sel_data;

    assign any_req = |req_valid;

`ifdef DIV_SHARE_RR_EN
    logic [1:0] ptr;
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest asserted requester
    // at or after the pointer is the last (and winning) assignment.
    always_comb begin
        grant = ptr;
        idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) grant = idx;
        end
    end

    // Pointer moves only when a response completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (state == ST_DONE && rsp_ready) begin
            ptr <= rsp_id + 2'd1;
        end
    end
`else
    always_comb begin
        grant = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[k]) grant = 2'(k);
        end
    end
`endif

    always_comb begin
        sel_data = req_data[WIDTH*grant +: WIDTH];
    end

    assign req_ready = (state == ST_IDLE && any_req) ? (4'b0001 << grant) : 4'b0000;
    assign rsp_data  = sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        sreg   <= sel_data;
                        rsp_id <= grant;
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
